// File: rtl/uart_tx_framer_if.sv
// Parallel-side bundle of the UART transmit framer: word handshake,
// frame options, break request and the status/serial outputs.
interface uart_tx_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_valid_txf;
    logic [DATA_WIDTH-1:0] p_data_txf;
    logic                  par_en_txf;
    logic                  par_typ_txf;
    logic                  break_txf;
    logic                  data_ack_txf;
    logic                  busy_txf;
    logic                  tx_out_txf;

    modport master (
        output data_valid_txf,
        output p_data_txf,
        output par_en_txf,
        output par_typ_txf,
        output break_txf,
        input  data_ack_txf,
        input  busy_txf,
        input  tx_out_txf
    );

    modport slave (
        input  data_valid_txf,
        input  p_data_txf,
        input  par_en_txf,
        input  par_typ_txf,
        input  break_txf,
        output data_ack_txf,
        output busy_txf,
        output tx_out_txf
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional
// parity, STOP_BITS stop bits. Runs on the baud clock, one bit per clock.
// The serial pin is driven straight from a flop.
//
// state  | meaning
// IDLE   | line high, waiting for a word or a break request
// BREAK  | line held low while break_txf is high
// START  | start bit (low), one clock
// DATA   | data bits, LSB first, cnt_q counts remaining bits down to 0
// PARITY | latched parity bit, one clock
// STOP   | stop bits (high), cnt_q counts remaining stop bits down to 0
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk_txf,
    input  logic              rst_txf,
    uart_tx_framer_if.slave   txf
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  ack_q, ack_d;
    logic                  accept;

    // State, shift register, counter and registered line driver.
    always_ff @(posedge clk_txf or posedge rst_txf) begin
        if (rst_txf) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state logic; tx_d is the bit of the state being entered.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        ack_d     = 1'b0;

        // A word may be taken from IDLE or in the final stop cycle, which
        // gives back-to-back frames with no idle gap. Break wins over data.
        accept = txf.data_valid_txf && !txf.break_txf &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (cnt_q == '0)));

        case (state_q)
            ST_IDLE: begin
                if (txf.break_txf) begin
                    state_d = ST_BREAK;
                    tx_d    = 1'b0;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            ST_BREAK: begin
                if (!txf.break_txf) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                tx_d    = shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = CNT_W'(DATA_WIDTH - 1);
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                        cnt_d   = CNT_W'(STOP_BITS - 1);
                    end
                end else begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
                cnt_d   = CNT_W'(STOP_BITS - 1);
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (txf.break_txf) begin
                        state_d = ST_BREAK;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    tx_d  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Accepting a word overrides the IDLE/STOP decisions above.
        if (accept) begin
            state_d   = ST_START;
            shreg_d   = txf.p_data_txf;
            par_en_d  = txf.par_en_txf;
            par_bit_d = txf.par_typ_txf ? ~^txf.p_data_txf : ^txf.p_data_txf;
            tx_d      = 1'b0;
            ack_d     = 1'b1;
        end
    end

    assign txf.tx_out_txf   = tx_q;
    assign txf.data_ack_txf = ack_q;
    assign txf.busy_txf     = (state_q != ST_IDLE) && (state_q != ST_BREAK);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: two instances (8 data/1 stop and 7 data/2 stop).
// Expected {tx, busy, ack} per clock are pushed to a queue from a frame model
// when stimulus is driven and popped one per clock as the DUT runs.
module tb_uart_tx_framer;

    logic clk_txf = 1'b0;
    logic rst_txf = 1'b1;

    uart_tx_framer_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_framer_if #(.DATA_WIDTH(7)) if7 ();

    uart_tx_framer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut8 (
        .clk_txf (clk_txf),
        .rst_txf (rst_txf),
        .txf     (if8.slave)
    );

    uart_tx_framer #(.DATA_WIDTH(7), .STOP_BITS(2)) dut7 (
        .clk_txf (clk_txf),
        .rst_txf (rst_txf),
        .txf     (if7.slave)
    );

    always #5 clk_txf = ~clk_txf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] q8[$];
    logic [2:0] q7[$];

    // Model of one frame: {tx, busy, ack} for every clock from the accept edge.
    function automatic void push_frame(int sel, logic [8:0] data, int width,
                                       bit pe, bit pt, int stops);
        logic [2:0] e[$];
        int ones = 0;
        e.push_back(3'b011);
        for (int b = 0; b < width; b++) begin
            e.push_back({data[b], 2'b10});
            if (data[b]) ones++;
        end
        if (pe) e.push_back({logic'((ones % 2) ^ int'(pt)), 2'b10});
        for (int s = 0; s < stops; s++) e.push_back(3'b110);
        foreach (e[k]) begin
            if (sel == 8) q8.push_back(e[k]);
            else          q7.push_back(e[k]);
        end
    endfunction

    function automatic void push_const(int sel, logic [2:0] v, int n);
        for (int k = 0; k < n; k++) begin
            if (sel == 8) q8.push_back(v);
            else          q7.push_back(v);
        end
    endfunction

    task automatic step();
        @(posedge clk_txf);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        rst_txf = 1'b1;
        #12;
        obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
        n_checks++;
        if (obs !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_w8: tx/busy/ack got %b expected 100", obs);
        end
        obs = {if7.tx_out_txf, if7.busy_txf, if7.data_ack_txf};
        n_checks++;
        if (obs !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_w7: tx/busy/ack got %b expected 100", obs);
        end
        rst_txf = 1'b0;
        step();
        obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
        n_checks++;
        if (obs !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_after_reset: tx/busy/ack got %b expected 100", obs);
        end
    endtask

    // One word on the 8-bit instance, then idle cycles.
    task automatic test_frame(string name, logic [7:0] data, bit pe, bit pt);
        logic [2:0] obs, e;
        int n;
        if8.p_data_txf     = data;
        if8.par_en_txf     = pe;
        if8.par_typ_txf    = pt;
        if8.data_valid_txf = 1'b1;
        push_frame(8, {1'b0, data}, 8, pe, pt, 1);
        push_const(8, 3'b100, 2);
        n = q8.size();
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) begin
                if8.data_valid_txf = 1'b0;
                if8.p_data_txf     = ~data;
                if8.par_en_txf     = ~pe;
                if8.par_typ_txf    = ~pt;
            end
            e   = q8.pop_front();
            obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cyc %0d: tx/busy/ack got %b expected %b", name, i, obs, e);
            end
        end
        if8.par_en_txf  = 1'b0;
        if8.par_typ_txf = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs, e;
        int n;
        if8.p_data_txf     = 8'h55;
        if8.par_en_txf     = 1'b0;
        if8.par_typ_txf    = 1'b0;
        if8.data_valid_txf = 1'b1;
        push_frame(8, 9'h055, 8, 1'b0, 1'b0, 1);
        push_frame(8, 9'h00F, 8, 1'b0, 1'b0, 1);
        push_const(8, 3'b100, 2);
        n = q8.size();
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0)  if8.p_data_txf     = 8'h0F;
            if (i == 10) if8.data_valid_txf = 1'b0;
            e   = q8.pop_front();
            obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: tx/busy/ack got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_break();
        logic [2:0] obs, e;
        int n;
        if8.p_data_txf     = 8'h3C;
        if8.par_en_txf     = 1'b0;
        if8.data_valid_txf = 1'b1;
        if8.break_txf      = 1'b1;
        push_const(8, 3'b000, 20);
        push_const(8, 3'b100, 1);
        push_frame(8, 9'h03C, 8, 1'b0, 1'b0, 1);
        push_const(8, 3'b100, 2);
        n = q8.size();
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 19) if8.break_txf      = 1'b0;
            if (i == 21) if8.data_valid_txf = 1'b0;
            e   = q8.pop_front();
            obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL break cyc %0d: tx/busy/ack got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] obs, e;
        int n;
        if8.p_data_txf     = 8'h96;
        if8.par_en_txf     = 1'b0;
        if8.data_valid_txf = 1'b1;
        push_frame(8, 9'h096, 8, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) if8.data_valid_txf = 1'b0;
            e   = q8.pop_front();
            obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mid_frame_pre cyc %0d: tx/busy/ack got %b expected %b", i, obs, e);
            end
        end
        q8.delete();
        #2 rst_txf = 1'b1;
        #1;
        obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
        n_checks++;
        if (obs !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset: tx/busy/ack got %b expected 100", obs);
        end
        #1 rst_txf = 1'b0;
        if8.p_data_txf     = 8'h5A;
        if8.data_valid_txf = 1'b1;
        push_frame(8, 9'h05A, 8, 1'b0, 1'b0, 1);
        push_const(8, 3'b100, 1);
        n = q8.size();
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) if8.data_valid_txf = 1'b0;
            e   = q8.pop_front();
            obs = {if8.tx_out_txf, if8.busy_txf, if8.data_ack_txf};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fresh_frame cyc %0d: tx/busy/ack got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_w7_s2();
        logic [2:0] obs, e;
        int n;
        if7.p_data_txf     = 7'h41;
        if7.par_en_txf     = 1'b1;
        if7.par_typ_txf    = 1'b0;
        if7.data_valid_txf = 1'b1;
        push_frame(7, 9'h041, 7, 1'b1, 1'b0, 2);
        push_const(7, 3'b100, 2);
        n = q7.size();
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) if7.data_valid_txf = 1'b0;
            e   = q7.pop_front();
            obs = {if7.tx_out_txf, if7.busy_txf, if7.data_ack_txf};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL w7_s2 cyc %0d: tx/busy/ack got %b expected %b", i, obs, e);
            end
        end
    endtask

    initial begin
        if8.data_valid_txf = 1'b0;
        if8.p_data_txf     = '0;
        if8.par_en_txf     = 1'b0;
        if8.par_typ_txf    = 1'b0;
        if8.break_txf      = 1'b0;
        if7.data_valid_txf = 1'b0;
        if7.p_data_txf     = '0;
        if7.par_en_txf     = 1'b0;
        if7.par_typ_txf    = 1'b0;
        if7.break_txf      = 1'b0;

        test_reset();
        test_frame("even_a5", 8'hA5, 1'b1, 1'b0);
        test_frame("odd_01", 8'h01, 1'b1, 1'b1);
        test_frame("nopar_ff", 8'hFF, 1'b0, 1'b0);
        test_frame("odd_c3", 8'hC3, 1'b1, 1'b1);
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        test_w7_s2();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
